// File: rtl/plru_victim_select.sv
// 4-way tree pseudo-LRU per set: hit way on a hit, victim way on a miss; response registered 1 cycle after accept.
// Accepts only while idle (acc_ready low during a 32-cycle flush sweep); response is never backpressured.
// Build option: define PLRU_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module plru_victim_select #(
  parameter int NUM_SETS = 32,
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SETS-1:0] set_sel,
  input  logic                acc_valid,
  output logic                acc_ready,
  input  logic                acc_hit,
  input  logic [1:0]          acc_hit_way,
  input  logic                flush,
  output logic                busy,
  output logic                resp_valid,
  output logic [1:0]          resp_way,
`ifdef PLRU_STATS_EN
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt,
`endif
  output logic                resp_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [2:0]       plru [NUM_SETS];
  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             sel_ok;
  logic             accept;
  logic [2:0]       cur_bits;
  logic [1:0]       victim;
  logic [1:0]       use_way;
  logic [2:0]       nxt_bits;

  assign acc_ready = (state == IDLE);
  assign busy      = (state == FLUSH);
  assign accept    = acc_valid & acc_ready;
  assign sel_ok    = (set_sel != '0) &&
                     ((set_sel & (set_sel - NUM_SETS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_SETS; i++) begin
      if (set_sel[i]) idx = IDX_W'(i);
    end
  end

  // Tree walk: b0 picks the half, b1/b2 pick the way inside the lower/upper half.
  always_comb begin
    cur_bits = plru[idx];
    victim   = cur_bits[0] ? (cur_bits[2] ? 2'd3 : 2'd2)
                           : (cur_bits[1] ? 2'd1 : 2'd0);
    use_way  = acc_hit ? acc_hit_way : victim;
    nxt_bits = cur_bits;
    if (!use_way[1]) begin
      nxt_bits[0] = 1'b1;
      nxt_bits[1] = (use_way == 2'd0);
    end else begin
      nxt_bits[0] = 1'b0;
      nxt_bits[2] = (use_way == 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_way   <= 2'd0;
      for (int i = 0; i < NUM_SETS; i++) plru[i] <= 3'b000;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept & ~sel_ok;
      resp_way   <= (accept && sel_ok) ? use_way : 2'd0;
      if (accept && sel_ok) plru[idx] <= nxt_bits;
      case (state)
        IDLE: begin
          if (flush) state <= FLUSH;
        end
        FLUSH: begin
          // Accesses are blocked here, so the sweep never races an update.
          plru[cnt] <= 3'b000;
          if (cnt == IDX_W'(NUM_SETS - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PLRU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept && sel_ok) begin
      if (acc_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (!acc_hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
